// File: rtl/mitchell_const_sub_pipe.sv
// ---------------------------------------------------------------------------
// mitchell_const_sub_pipe
//
// Pipelined "K - a" stage for the Mitchell error-tolerant multiplier. It sits
// between the leading-one/characteristic stage and the mantissa shifter.
// There are LANES independent lanes. Each lane computes K - a on a WIDTH+1
// bit difference. The MSB of that difference is the per-lane underflow flag
// (a > K).
//
// K is either KDEF (mode = 0) or the programmable k_reg (mode = 1). k_reg is
// written through cfg_we/cfg_k. The write takes effect at the clock edge, so
// an accept in the same cycle still uses the old value.
//
// The output is a single register stage with a valid/ready handshake:
//   in_ready = !out_valid || out_ready   (combinational from out_ready)
// This gives full throughput when the downstream drains every cycle.
//
// uf_count accumulates the underflowing lanes of every accepted transfer and
// saturates at 2^CNTW - 1.
//
// Optional build macro:
//   MITCHELL_CSUB_SAT_EN - when defined, an underflowing lane outputs 0
//                          instead of the wrapped difference. Flags and the
//                          counter are identical in both builds.
//
// Ports:
//   clk       in   1            clock, rising edge
//   rst_n     in   1            asynchronous active-low reset
//   in_valid  in   1            operands valid
//   in_ready  out  1            block can accept this cycle
//   in_a      in   LANES*WIDTH  packed operands, lane i = [i*WIDTH +: WIDTH]
//   mode      in   1            0 = KDEF, 1 = k_reg (sampled on accept)
//   cfg_we    in   1            k_reg write enable
//   cfg_k     in   WIDTH        new k_reg value
//   out_valid out  1            result valid
//   out_ready in   1            downstream accepts result
//   out_c     out  LANES*WIDTH  packed results
//   out_uf    out  LANES        per-lane underflow flags of held result
//   uf_count  out  CNTW         saturating count of lane underflows
// ---------------------------------------------------------------------------
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no result held, out_valid = 0
// ST_FULL  | result held in output registers, out_valid = 1
// ---------------------------------------------------------------------------
module mitchell_const_sub_pipe #(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int KDEF  = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic                     mode,
    input  logic                     cfg_we,
    input  logic [WIDTH-1:0]         cfg_k,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_c,
    output logic [LANES-1:0]         out_uf,
    output logic [CNTW-1:0]          uf_count
);

    localparam logic [WIDTH-1:0] K_DEF_W = KDEF[WIDTH-1:0];
    localparam logic [CNTW:0]    CNT_MAX = {1'b0, {CNTW{1'b1}}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [WIDTH-1:0]         r_k;
    logic [LANES*WIDTH-1:0]   r_c;
    logic [LANES-1:0]         r_uf;
    logic [CNTW-1:0]          r_cnt;

    logic                     w_accept;
    logic [WIDTH-1:0]         w_k;
    logic [WIDTH:0]           w_d [LANES];
    logic [LANES*WIDTH-1:0]   w_c;
    logic [LANES-1:0]         w_uf;
    logic [CNTW:0]            w_pop;
    logic [CNTW:0]            w_sum;
    logic [CNTW-1:0]          w_cnt_nxt;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_accept)       w_state_nxt = ST_FULL;
                else if (out_ready) w_state_nxt = ST_EMPTY;
            end
            default:                w_state_nxt = ST_EMPTY;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        out_valid = (r_state == ST_FULL);
        in_ready  = (r_state == ST_EMPTY) || out_ready;
    end

    assign w_accept = in_valid && in_ready;

    // The old k_reg is used here; a same-cycle cfg write lands on the edge.
    assign w_k = mode ? r_k : K_DEF_W;

    // ---------------- per-lane subtract ----------------
    always_comb begin
        w_d   = '{default: '0};
        w_c   = '0;
        w_uf  = '0;
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_d[i]  = {1'b0, w_k} - {1'b0, in_a[i*WIDTH +: WIDTH]};
            w_uf[i] = w_d[i][WIDTH];
`ifdef MITCHELL_CSUB_SAT_EN
            w_c[i*WIDTH +: WIDTH] = w_d[i][WIDTH] ? '0 : w_d[i][WIDTH-1:0];
`else
            w_c[i*WIDTH +: WIDTH] = w_d[i][WIDTH-1:0];
`endif
            w_pop = w_pop + {{CNTW{1'b0}}, w_d[i][WIDTH]};
        end
    end

    // One extra bit of headroom so the add can be checked against the ceiling.
    always_comb begin
        w_sum     = {1'b0, r_cnt} + w_pop;
        w_cnt_nxt = (w_sum > CNT_MAX) ? CNT_MAX[CNTW-1:0] : w_sum[CNTW-1:0];
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= K_DEF_W;
        end else if (cfg_we) begin
            r_k <= cfg_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c   <= '0;
            r_uf  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_c   <= w_c;
            r_uf  <= w_uf;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign out_c    = r_c;
    assign out_uf   = r_uf;
    assign uf_count = r_cnt;

endmodule

// File: tb/tb_mitchell_const_sub_pipe.sv
module tb_mitchell_const_sub_pipe;

    logic        clk;
    logic        rst_n;

    // default-parameter instance
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic        mode;
    logic        cfg_we;
    logic [7:0]  cfg_k;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_c;
    logic [1:0]  out_uf;
    logic [15:0] uf_count;

    // CNTW = 4 instance for counter saturation
    logic        in_valid4;
    logic        in_ready4;
    logic [15:0] in_a4;
    logic        out_valid4;
    logic        out_ready4;
    logic [15:0] out_c4;
    logic [1:0]  out_uf4;
    logic [3:0]  uf_count4;

    int checks;
    int errors;

    mitchell_const_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .mode      (mode),
        .cfg_we    (cfg_we),
        .cfg_k     (cfg_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_uf    (out_uf),
        .uf_count  (uf_count)
    );

    mitchell_const_sub_pipe #(.CNTW(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_a      (in_a4),
        .mode      (1'b0),
        .cfg_we    (1'b0),
        .cfg_k     (8'd0),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_c     (out_c4),
        .out_uf    (out_uf4),
        .uf_count  (uf_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted beat: drive at negedge, sample 1 time unit after posedge.
    task automatic send(input logic [15:0] a, input logic m);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        mode     = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_c !== 16'h0) begin errors++; $display("FAIL reset_out_c: got %h expected 0000", out_c); end
        checks++;
        if (out_uf !== 2'b00) begin errors++; $display("FAIL reset_out_uf: got %b expected 00", out_uf); end
        checks++;
        if (uf_count !== 16'd0) begin errors++; $display("FAIL reset_uf_count: got %0d expected 0", uf_count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        send({8'd3, 8'd8}, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_c !== {8'd5, 8'd0}) begin errors++; $display("FAIL basic_out_c: got %h expected 0500", out_c); end
        checks++;
        if (out_uf !== 2'b00) begin errors++; $display("FAIL basic_out_uf: got %b expected 00", out_uf); end
        checks++;
        if (uf_count !== 16'd0) begin errors++; $display("FAIL basic_uf_count: got %0d expected 0", uf_count); end
    endtask

    task automatic test_underflow;
        logic [15:0] exp_c;
`ifdef MITCHELL_CSUB_SAT_EN
        exp_c = {8'd0, 8'd8};
`else
        exp_c = {8'd255, 8'd8};
`endif
        send({8'd9, 8'd0}, 1'b0);
        checks++;
        if (out_c !== exp_c) begin errors++; $display("FAIL uf_out_c: got %h expected %h", out_c, exp_c); end
        checks++;
        if (out_uf !== 2'b10) begin errors++; $display("FAIL uf_out_uf: got %b expected 10", out_uf); end
        checks++;
        if (uf_count !== 16'd1) begin errors++; $display("FAIL uf_count_1: got %0d expected 1", uf_count); end
    endtask

    task automatic test_cfg_same_cycle;
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_k    = 8'd20;
        in_valid = 1'b1;
        in_a     = {8'd4, 8'd4};
        mode     = 1'b1;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_c !== {8'd4, 8'd4}) begin errors++; $display("FAIL cfg_old_k: got %h expected 0404", out_c); end
        send({8'd4, 8'd4}, 1'b1);
        checks++;
        if (out_c !== {8'd16, 8'd16}) begin errors++; $display("FAIL cfg_new_k: got %h expected 1010", out_c); end
        checks++;
        if (out_uf !== 2'b00) begin errors++; $display("FAIL cfg_out_uf: got %b expected 00", out_uf); end
    endtask

    task automatic test_stream_stall;
        logic [15:0] a_v [6];
        logic [15:0] c_v [6];
        a_v = '{ {8'd1, 8'd2}, {8'd2, 8'd3}, {8'd3, 8'd4}, {8'd4, 8'd5}, {8'd5, 8'd6}, {8'd6, 8'd7} };
        c_v = '{ {8'd7, 8'd6}, {8'd6, 8'd5}, {8'd5, 8'd4}, {8'd4, 8'd3}, {8'd3, 8'd2}, {8'd2, 8'd1} };
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = a_v[i];
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_c !== c_v[i])
                begin errors++; $display("FAIL stream_beat%0d: got v=%b c=%h expected v=1 c=%h", i, out_valid, out_c, c_v[i]); end
        end
        @(negedge clk);
        in_a      = a_v[4];
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_c !== c_v[3] || in_ready !== 1'b0)
                begin errors++; $display("FAIL stall_cyc%0d: got v=%b c=%h rdy=%b expected v=1 c=%h rdy=0", i, out_valid, out_c, in_ready, c_v[3]); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL unstall_in_ready: got %b expected 1", in_ready); end
        for (int i = 4; i < 6; i++) begin
            if (i > 4) begin
                @(negedge clk);
                in_a = a_v[i];
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_c !== c_v[i])
                begin errors++; $display("FAIL resume_beat%0d: got v=%b c=%h expected v=1 c=%h", i, out_valid, out_c, c_v[i]); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
        checks++;
        if (uf_count !== 16'd1) begin errors++; $display("FAIL stream_uf_count: got %0d expected 1", uf_count); end
    endtask

    task automatic test_async_reset;
        // move k_reg away from its reset value first
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_k  = 8'd30;
        @(negedge clk);
        cfg_we    = 1'b0;
        out_ready = 1'b0;
        send({8'd1, 8'd1}, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (uf_count !== 16'd0) begin errors++; $display("FAIL async_uf_count: got %0d expected 0", uf_count); end
        checks++;
        if (out_c !== 16'h0) begin errors++; $display("FAIL async_out_c: got %h expected 0000", out_c); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send({8'd1, 8'd1}, 1'b1);
        checks++;
        if (out_c !== {8'd7, 8'd7}) begin errors++; $display("FAIL k_reset_out_c: got %h expected 0707", out_c); end
    endtask

    task automatic test_saturation;
        logic [3:0] exp_cnt;
        out_ready4 = 1'b1;
        in_a4      = {8'd9, 8'd9};
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            in_valid4 = 1'b1;
            @(posedge clk);
            #1;
            exp_cnt = (2 * i > 15) ? 4'd15 : 4'(2 * i);
            checks++;
            if (uf_count4 !== exp_cnt) begin errors++; $display("FAIL sat_beat%0d: got %0d expected %0d", i, uf_count4, exp_cnt); end
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        checks++;
        if (out_uf4 !== 2'b11) begin errors++; $display("FAIL sat_out_uf: got %b expected 11", out_uf4); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        mode      = 1'b0;
        cfg_we    = 1'b0;
        cfg_k     = '0;
        out_ready = 1'b1;
        in_valid4 = 1'b0;
        in_a4     = '0;
        out_ready4 = 1'b1;
        #2;
        test_reset();
        test_basic();
        test_underflow();
        test_cfg_same_cycle();
        test_stream_stall();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
